// File: rtl/lzd_seq_norm.sv
// rtl/lzd_seq_norm.sv - sequential chunked leading-zero detector and normalizer
// Scans the operand MSB chunk first, one CHUNK-bit LZD per cycle, then shifts in a separate cycle.
module lzd_seq_norm #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] out_zp,
  output logic                     out_zv,
  output logic [WIDTH-1:0]         out_norm,
  output logic                     busy
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int LZ_W  = $clog2(CHUNK);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   zp_q, zp_d;
  logic               zv_q, zv_d;
  logic [WIDTH-1:0]   norm_q, norm_d;

  logic [CHUNK-1:0]   chunk;
  logic [LZ_W-1:0]    chunk_lz;

  always_comb begin
    chunk = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_q == IDX_W'(i)) chunk = data_q[WIDTH-1-i*CHUNK -: CHUNK];
    end
  end

  // Highest set bit wins since later iterations overwrite earlier ones.
  always_comb begin
    chunk_lz = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) chunk_lz = LZ_W'(CHUNK - 1 - i);
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    zp_d    = zp_q;
    zv_d    = zv_q;
    norm_d  = norm_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (chunk != '0) begin
          cnt_d   = cnt_q + CNT_W'(chunk_lz);
          state_d = SHIFT;
        end else if (idx_q == IDX_W'(NCH - 1)) begin
          zp_d    = '0;
          zv_d    = 1'b0;
          norm_d  = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(CHUNK);
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SHIFT: begin
        norm_d  = data_q << cnt_q;
        zp_d    = cnt_q;
        zv_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      zp_q    <= '0;
      zv_q    <= 1'b0;
      norm_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      zp_q    <= zp_d;
      zv_q    <= zv_d;
      norm_q  <= norm_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_zp    = zp_q;
  assign out_zv    = zv_q;
  assign out_norm  = norm_q;

endmodule

// File: doc/lzd_seq_norm.md
LZD_SEQ_NORM -- requirements
Module: lzd_seq_norm

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand width; power of two; multiple of CHUNK.
REQ-002 SHALL have parameter CHUNK, default 16: bits examined per scan cycle; power of two, >= 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand offered.
REQ-006 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-007 SHALL have port in_data, input, WIDTH: operand to normalize.
REQ-008 SHALL have port out_valid, output, 1: result available.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-010 SHALL have port out_zp, output, $clog2(WIDTH): leading-zero count.
REQ-011 SHALL have port out_zv, output, 1: 1 = operand contained at least one 1 (out_zp valid); 0 = operand all zero.
REQ-012 SHALL have port out_norm, output, WIDTH: operand shifted left by out_zp.
REQ-013 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, SCAN, SHIFT and DONE.
REQ-015 SHALL assert in_ready only in IDLE; an operand is accepted on an edge with in_valid && in_ready, capturing in_data, clearing the chunk index and count, and entering SCAN.
REQ-016 SHALL ignore in_data changes after acceptance; only the captured operand is used.
REQ-017 SHALL, in SCAN, examine the captured chunk at the current index, MSB chunk first (index 0 = bits WIDTH-1 down to WIDTH-CHUNK), using one CHUNK-bit leading-zero detector per cycle.
REQ-018 SHALL, in SCAN with a nonzero chunk, add that chunk's leading-zero count to the count and go to SHIFT.
REQ-019 SHALL, in SCAN with a zero chunk that is not the last, add CHUNK to the count, increment the index and remain in SCAN.
REQ-020 SHALL, in SCAN with a zero last chunk (index WIDTH/CHUNK-1), go to DONE with out_zv=0, out_zp=0 and out_norm=0.
REQ-021 SHALL, in SHIFT, register out_norm = operand << count, out_zp = count and out_zv=1 in one cycle, then go to DONE.
REQ-022 SHALL assert out_valid only in DONE, holding out_zp, out_zv and out_norm stable while out_ready=0.
REQ-023 SHALL return to IDLE on an edge in DONE with out_ready=1; in_ready rises the following cycle, with no same-cycle bypass.
REQ-024 SHALL have a latency from the acceptance edge to out_valid=1 of k+2 cycles when the first nonzero chunk is at index k, and WIDTH/CHUNK cycles for an all-zero operand.
REQ-025 SHALL keep the count width at $clog2(WIDTH) bits; the maximum count is WIDTH-1, so the count does not overflow.

Reset
REQ-026 SHALL, with reset=1 at an edge, enter IDLE and clear out_valid, out_zp, out_zv, out_norm, busy, the count and the index; in_ready=1 the next cycle.
REQ-027 SHALL give reset priority over in_valid and out_ready in the same cycle, so no operand is accepted on a reset edge.
REQ-028 SHALL, when reset is asserted mid-operation (SCAN, SHIFT or DONE), abandon the operation with no result emitted.

Verification (WIDTH=64, CHUNK=16)
REQ-029 SHALL cover: in_data=64'h8000_0000_0000_0000 -> out_zp=0, out_zv=1, out_norm=64'h8000_0000_0000_0000, out_valid 2 cycles after acceptance.
REQ-030 SHALL cover: in_data=64'h0000_0000_0000_0001 -> out_zp=63, out_zv=1, out_norm=64'h8000_0000_0000_0000, latency 5.
REQ-031 SHALL cover: in_data=64'h0 -> out_zp=0, out_zv=0, out_norm=0, latency 4.
REQ-032 SHALL cover: in_data=64'h0000_0123_4567_89AB -> out_zp=23, out_zv=1, out_norm=64'h91A2_B3C4_D580_0000, latency 3.
REQ-033 SHALL cover: out_ready held 0 for 3 cycles in DONE, with in_valid=1 and in_data changing -> outputs stable, in_ready=0, nothing accepted; out_ready=1 -> IDLE, in_ready=1 the next cycle.
REQ-034 SHALL cover: reset pulsed during SCAN of an all-zero operand -> next cycle out_valid=0, busy=0, in_ready=1; the following operand 64'h1 gives out_zp=63 with correct latency.
